seq_pattern_store: RTL and testbench
====================================

SEQ_PATTERN_STORE -- requirements
Module: seq_pattern_store

Interface
REQ-001 SHALL have parameter NUM_TRACKS, default 4: number of independent pitch tracks.
REQ-002 SHALL have parameter NUM_STEPS, default 16: steps per track, at least 2, not necessarily a power of two.
REQ-003 SHALL have parameter PITCH_W, default 4: pitch code width; value 0 means rest.
REQ-004 SHALL use SW = $clog2(NUM_STEPS) and TW = max(1, $clog2(NUM_TRACKS)) as index widths.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port wr_valid, input, 1: write request.
REQ-008 SHALL have port wr_ready, output, 1: write accepted when high with wr_valid.
REQ-009 SHALL have port wr_track, input, TW: target track.
REQ-010 SHALL have port wr_step, input, SW: target step.
REQ-011 SHALL have port wr_pitch, input, PITCH_W: pitch to store.
REQ-012 SHALL have port wr_err, output, 1: one-cycle pulse on an accepted out-of-range write.
REQ-013 SHALL have port clr_valid, input, 1: request to clear one whole track.
REQ-014 SHALL have port clr_track, input, TW: track to clear.
REQ-015 SHALL have port busy, output, 1: clear in progress.
REQ-016 SHALL have port play_en, input, 1: playback enable.
REQ-017 SHALL have port tick, input, 1: single-cycle step strobe.
REQ-018 SHALL have port restart, input, 1: return playhead to step 0.
REQ-019 SHALL have port pat_len, input, SW+1: active pattern length; 0 or values above NUM_STEPS mean NUM_STEPS.
REQ-020 SHALL have port step_idx, output, SW: next step to play.
REQ-021 SHALL have port notes, output, NUM_TRACKS*PITCH_W: played pitches, track t in bits [t*PITCH_W +: PITCH_W].
REQ-022 SHALL have port note_valid, output, 1: one-cycle pulse when notes updates.

Function
REQ-023 SHALL store NUM_TRACKS x NUM_STEPS pitch entries, each all zeros after reset.
REQ-024 SHALL implement an FSM with states IDLE and CLEAR, where IDLE goes to CLEAR on clr_valid and CLEAR returns to IDLE after its final step.
REQ-025 SHALL drive wr_ready = 1 only in IDLE and busy = 1 only in CLEAR; clr_valid in CLEAR is ignored.
REQ-026 SHALL, on an accepted write, update the entry at the rising edge of acceptance, with the new value visible to the next tick.
REQ-027 SHALL, on an accepted write with wr_track >= NUM_TRACKS or wr_step >= NUM_STEPS, leave memory unchanged and pulse wr_err the following cycle.
REQ-028 SHALL, in CLEAR, zero one step of clr_track (latched at entry) per cycle, from step 0 to NUM_STEPS-1, taking exactly NUM_STEPS cycles.
REQ-029 SHALL treat an out-of-range clr_track as a full-length CLEAR that modifies nothing.
REQ-030 SHALL, when wr_valid and clr_valid coincide in IDLE, perform the write first and then clear, so a write to the same track is erased.
REQ-031 SHALL, on tick with play_en = 1, register notes from entries at step_idx of all tracks, pulse note_valid next cycle, and advance step_idx.
REQ-032 SHALL wrap step_idx from effective length-1 to 0, and reset it to 0 on the next tick if pat_len shrinks below step_idx+1.
REQ-033 SHALL ignore tick when play_en = 0, holding notes, step_idx and note_valid = 0.
REQ-034 SHALL, on restart without an enabled tick, set step_idx to 0 without a note_valid pulse.
REQ-035 SHALL, on restart with an enabled tick, play step 0 and set step_idx to 1.
REQ-036 SHALL have playback read pre-edge memory on a simultaneous write to the same entry, so the old value plays.
REQ-037 SHALL continue playback during CLEAR, with already-zeroed steps reading 0.

Reset
REQ-038 SHALL, on rst_n low, immediately set state IDLE, all entries 0, step_idx 0, notes 0, note_valid 0, wr_err 0 and busy 0.
REQ-039 SHALL abandon a CLEAR on reset mid-operation and leave no residual state.
REQ-040 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-041 SHALL pass: write track 2 step 5 pitch 9, pat_len 0, 6 enabled ticks -> 6th note_valid shows notes[11:8] = 9 and others 0.
REQ-042 SHALL pass: pat_len 3 with 4 ticks -> step_idx sequence 1, 2, 0, 1.
REQ-043 SHALL pass: fill track 1 with pitch 7, clr_valid track 1 -> busy high 16 cycles, wr_ready low, all track-1 entries then 0.
REQ-044 SHALL pass: write to step 16 with NUM_STEPS = 16 padded, or track 5 -> wr_err pulses once and memory is unchanged.
REQ-045 SHALL pass: restart with tick at step_idx 9 -> step 0 plays and step_idx becomes 1.
REQ-046 SHALL pass: rst_n low for 1 cycle mid-CLEAR -> all outputs 0, busy 0 and a new write is accepted the next cycle.

Source files
------------

// File: rtl/seq_pattern_store.sv
// Step-sequencer pattern memory: NUM_TRACKS x NUM_STEPS pitch codes, a host
// write/track-clear port, and tick-driven playback of every track in parallel.
module seq_pattern_store #(
    parameter int NUM_TRACKS = 4,
    parameter int NUM_STEPS  = 16,
    parameter int PITCH_W    = 4,
    localparam int SW = $clog2(NUM_STEPS),
    localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [TW-1:0]                   wr_track,
    input  logic [SW-1:0]                   wr_step,
    input  logic [PITCH_W-1:0]              wr_pitch,
    output logic                            wr_err,
    input  logic                            clr_valid,
    input  logic [TW-1:0]                   clr_track,
    output logic                            busy,
    input  logic                            play_en,
    input  logic                            tick,
    input  logic                            restart,
    input  logic [SW:0]                     pat_len,
    output logic [SW-1:0]                   step_idx,
    output logic [NUM_TRACKS*PITCH_W-1:0]   notes,
    output logic                            note_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic [TW-1:0]                 clr_track_q, clr_track_d;
    logic [SW-1:0]                 clr_step_q, clr_step_d;
    logic [SW-1:0]                 step_idx_q, step_idx_d;
    logic [NUM_TRACKS*PITCH_W-1:0] notes_q, notes_d;
    logic                          note_valid_q;
    logic                          wr_err_q;
    logic [PITCH_W-1:0]            mem_q [NUM_TRACKS][NUM_STEPS];

    logic          wr_fire, wr_in_range, wr_commit, clr_en, play;
    logic [SW-1:0] play_idx;
    logic [SW:0]   len_eff, play_inc;

    assign wr_ready    = (state_q == IDLE);
    assign busy        = (state_q == CLEAR);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (int'(wr_track) < NUM_TRACKS) && (int'(wr_step) < NUM_STEPS);
    assign wr_commit   = wr_fire && wr_in_range;
    // An out-of-range clear still walks every step; it just never hits an entry.
    assign clr_en      = busy && (int'(clr_track_q) < NUM_TRACKS);

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        clr_track_d = clr_track_q;
        clr_step_d  = clr_step_q;
        case (state_q)
            IDLE: begin
                if (clr_valid) begin
                    state_d     = CLEAR;
                    clr_track_d = clr_track;
                    clr_step_d  = '0;
                end
            end
            CLEAR: begin
                clr_step_d = clr_step_q + SW'(1);
                if (clr_step_q == SW'(NUM_STEPS - 1)) begin
                    state_d    = IDLE;
                    clr_step_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_eff = ((pat_len == '0) || (pat_len > (SW+1)'(NUM_STEPS))) ? (SW+1)'(NUM_STEPS) : pat_len;
        play     = play_en && tick;
        play_idx = restart ? '0 : step_idx_q;
        play_inc = {1'b0, play_idx} + (SW+1)'(1);
        step_idx_d = step_idx_q;
        notes_d    = notes_q;
        if (play) begin
            // ">=" also folds a playhead stranded beyond a shrunken length back to 0.
            step_idx_d = (play_inc >= len_eff) ? '0 : play_inc[SW-1:0];
            for (int t = 0; t < NUM_TRACKS; t++) begin
                notes_d[t*PITCH_W +: PITCH_W] = mem_q[t][play_idx];
            end
        end else if (restart) begin
            step_idx_d = '0;
        end
    end

    // NOTE: the pattern memory is reset because every entry must read as a rest after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                for (int s = 0; s < NUM_STEPS; s++) begin
                    mem_q[t][s] <= '0;
                end
            end
        end else begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                for (int s = 0; s < NUM_STEPS; s++) begin
                    if (wr_commit && wr_track == TW'(t) && wr_step == SW'(s)) begin
                        mem_q[t][s] <= wr_pitch;
                    end else if (clr_en && clr_track_q == TW'(t) && clr_step_q == SW'(s)) begin
                        mem_q[t][s] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clr_track_q  <= '0;
            clr_step_q   <= '0;
            step_idx_q   <= '0;
            notes_q      <= '0;
            note_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_track_q  <= clr_track_d;
            clr_step_q   <= clr_step_d;
            step_idx_q   <= step_idx_d;
            notes_q      <= notes_d;
            note_valid_q <= play;
            wr_err_q     <= wr_fire && !wr_in_range;
        end
    end

    assign step_idx   = step_idx_q;
    assign notes      = notes_q;
    assign note_valid = note_valid_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_seq_pattern_store.sv
// Scoreboard bench for seq_pattern_store; built with 3 tracks x 12 steps so that
// out-of-range tracks and steps are reachable on the index ports.
module tb_seq_pattern_store;
    localparam int NT = 3;
    localparam int NS = 12;
    localparam int PW = 4;
    localparam int SW = $clog2(NS);
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_valid = 1'b0, wr_ready, wr_err;
    logic [TW-1:0]     wr_track = '0;
    logic [SW-1:0]     wr_step = '0;
    logic [PW-1:0]     wr_pitch = '0;
    logic              clr_valid = 1'b0, busy;
    logic [TW-1:0]     clr_track = '0;
    logic              play_en = 1'b0, tick = 1'b0, restart = 1'b0;
    logic [SW:0]       pat_len = '0;
    logic [SW-1:0]     step_idx;
    logic [NT*PW-1:0]  notes;
    logic              note_valid;

    seq_pattern_store #(.NUM_TRACKS(NT), .NUM_STEPS(NS), .PITCH_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_track(wr_track), .wr_step(wr_step),
        .wr_pitch(wr_pitch), .wr_err(wr_err),
        .clr_valid(clr_valid), .clr_track(clr_track), .busy(busy),
        .play_en(play_en), .tick(tick), .restart(restart), .pat_len(pat_len),
        .step_idx(step_idx), .notes(notes), .note_valid(note_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the pattern as a plain array, playhead as an int,
    // a clear as "track, position" walked one entry per clock.
    typedef struct {
        int               due;
        logic [NT*PW-1:0] notes;
    } note_exp_t;

    note_exp_t        note_q[$];
    int               err_q[$];
    logic [PW-1:0]    m_mem [NT][NS];
    int               m_step = 0;
    bit               m_busy = 0;
    int               m_clr_trk = 0;
    int               m_clr_pos = 0;
    logic [NT*PW-1:0] last_notes = '0;

    task automatic model_reset();
        for (int t = 0; t < NT; t++)
            for (int s = 0; s < NS; s++)
                m_mem[t][s] = '0;
        m_step = 0;
        m_busy = 0;
        note_q.delete();
        err_q.delete();
        last_notes = '0;
    endtask

    // Applies the effect of the coming rising edge using the current inputs.
    task automatic model_edge();
        int p, len;
        logic [NT*PW-1:0] n;
        if (play_en && tick) begin
            p = restart ? 0 : m_step;
            for (int t = 0; t < NT; t++) n[t*PW +: PW] = m_mem[t][p];
            note_q.push_back('{due: cyc + 1, notes: n});
            len = (pat_len == 0 || pat_len > NS) ? NS : int'(pat_len);
            m_step = (p + 1 >= len) ? 0 : p + 1;
        end else if (restart) begin
            m_step = 0;
        end
        if (m_busy) begin
            if (m_clr_trk < NT) m_mem[m_clr_trk][m_clr_pos] = '0;
            m_clr_pos++;
            if (m_clr_pos == NS) m_busy = 0;
        end else begin
            if (wr_valid) begin
                if (wr_track < NT && wr_step < NS) m_mem[wr_track][wr_step] = wr_pitch;
                else err_q.push_back(cyc + 1);
            end
            if (clr_valid) begin
                m_busy    = 1;
                m_clr_trk = int'(clr_track);
                m_clr_pos = 0;
            end
        end
    endtask

    // Monitor: samples on the falling edge, consumes scoreboard entries on pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("wr_ready", {31'd0, wr_ready}, {31'd0, !m_busy});
            check("step_idx", 32'(step_idx), 32'(m_step));
            if (note_q.size() > 0 && note_q[0].due == cyc) begin
                check("note_valid_pulse", {31'd0, note_valid}, 32'd1);
                check("notes", 32'(notes), 32'(note_q[0].notes));
                last_notes = note_q[0].notes;
                void'(note_q.pop_front());
            end else begin
                check("note_valid_idle", {31'd0, note_valid}, 32'd0);
                check("notes_hold", 32'(notes), 32'(last_notes));
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                check("wr_err_pulse", {31'd0, wr_err}, 32'd1);
                void'(err_q.pop_front());
            end else begin
                check("wr_err_idle", {31'd0, wr_err}, 32'd0);
            end
        end
    end

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 0; clr_valid = 0; tick = 0; restart = 0;
    endtask

    task automatic write(input int t, input int s, input int p);
        wr_valid = 1; wr_track = TW'(t); wr_step = SW'(s); wr_pitch = PW'(p);
        step();
        wr_valid = 0;
    endtask

    task automatic tick_once();
        play_en = 1; tick = 1;
        step();
        tick = 0;
    endtask

    task automatic do_restart();
        restart = 1;
        step();
        restart = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_step_idx", 32'(step_idx), 32'd0);
        check("rst_notes", 32'(notes), 32'd0);
        check("rst_note_valid", {31'd0, note_valid}, 32'd0);
        check("rst_wr_err", {31'd0, wr_err}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic wait_not_busy(input string name);
        int n = 0;
        for (int i = 0; i < 4 * NS && busy; i++) begin
            n++;
            step();
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seq042 [4] = '{1, 2, 0, 1};
        int nbusy, nlow;
        logic [PW-1:0] acc;

        model_reset();
        #1;
        do_reset();

        // Single write heard on the 6th tick of a full-length pattern.
        pat_len = '0;
        write(2, 5, 9);
        for (int i = 0; i < 6; i++) tick_once();
        check("req041_valid", {31'd0, note_valid}, 32'd1);
        check("req041_notes", 32'(notes), 32'h900);
        check("req041_idx", 32'(step_idx), 32'd6);

        // Short pattern wraps.
        do_restart();
        pat_len = 5'd3;
        for (int i = 0; i < 4; i++) begin
            tick_once();
            check("req042_idx", 32'(step_idx), 32'(seq042[i]));
        end

        // Fill track 1, then clear it.
        pat_len = '0;
        for (int s = 0; s < NS; s++) write(1, s, 7);
        clr_valid = 1; clr_track = 2'd1;
        step();
        clr_valid = 0;
        nbusy = 0; nlow = 0;
        for (int i = 0; i < 4 * NS && busy; i++) begin
            nbusy++;
            if (!wr_ready) nlow++;
            step();
        end
        check("req043_busy_cycles", 32'(nbusy), 32'(NS));
        check("req043_ready_low", 32'(nlow), 32'(NS));
        do_restart();
        acc = '0;
        for (int s = 0; s < NS; s++) begin
            tick_once();
            acc |= notes[1*PW +: PW];
        end
        check("req043_track1_zero", 32'(acc), 32'd0);

        // Out-of-range writes.
        write(0, NS, 5);
        check("req044_err_step", {31'd0, wr_err}, 32'd1);
        step();
        check("req044_err_once", {31'd0, wr_err}, 32'd0);
        write(3, 2, 6);
        check("req044_err_track", {31'd0, wr_err}, 32'd1);
        step();
        do_restart();
        for (int s = 0; s < NS; s++) tick_once();

        // Restart together with a tick.
        write(0, 0, 3);
        do_restart();
        for (int i = 0; i < 9; i++) tick_once();
        check("req045_at9", 32'(step_idx), 32'd9);
        restart = 1;
        tick_once();
        restart = 0;
        check("req045_idx", 32'(step_idx), 32'd1);
        check("req045_notes", 32'(notes), 32'h003);

        // Tick ignored while playback disabled.
        play_en = 0; tick = 1;
        step();
        tick = 0; play_en = 1;
        check("req033_idx", 32'(step_idx), 32'd1);
        check("req033_nv", {31'd0, note_valid}, 32'd0);

        // Write and play the same entry on one edge: old value plays.
        wr_valid = 1; wr_track = 2'd0; wr_step = 4'd1; wr_pitch = 4'd4; tick = 1;
        step();
        idle_inputs();
        check("req036_old", 32'(notes[PW-1:0]), 32'd0);
        do_restart();
        tick_once();
        tick_once();
        check("req036_new", 32'(notes[PW-1:0]), 32'd4);

        // Write and clear coincide on the same track: write is erased.
        wr_valid = 1; wr_track = 2'd2; wr_step = 4'd3; wr_pitch = 4'd8;
        clr_valid = 1; clr_track = 2'd2;
        step();
        idle_inputs();
        wait_not_busy("req030_clear_done");
        do_restart();
        acc = '0;
        for (int s = 0; s < NS; s++) begin
            tick_once();
            acc |= notes[2*PW +: PW];
        end
        check("req030_track2_zero", 32'(acc), 32'd0);

        // Reset in the middle of a clear.
        clr_valid = 1; clr_track = 2'd0;
        step();
        clr_valid = 0;
        for (int i = 0; i < 5; i++) step();
        check("req046_busy_mid", {31'd0, busy}, 32'd1);
        do_reset();
        check("req046_ready", {31'd0, wr_ready}, 32'd1);
        write(0, 0, 5);
        restart = 1;
        tick_once();
        restart = 0;
        check("req046_notes", 32'(notes), 32'h005);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            wr_valid  = ($urandom_range(0, 3) == 0);
            wr_track  = TW'($urandom_range(0, 3));
            wr_step   = SW'($urandom_range(0, 15));
            wr_pitch  = PW'($urandom_range(0, 15));
            clr_valid = ($urandom_range(0, 40) == 0);
            clr_track = TW'($urandom_range(0, 3));
            play_en   = ($urandom_range(0, 7) != 0);
            tick      = ($urandom_range(0, 2) == 0);
            restart   = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 60) == 0) pat_len = (SW+1)'($urandom_range(0, 20));
            step();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        check("drain_notes", 32'(note_q.size()), 32'd0);
        check("drain_err", 32'(err_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
